// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array output path.
package systolic_pkg;

  localparam int WIDTH_D  = 16;
  localparam int N_COLS   = 4;
  localparam int AXIS_W_D = 32;
  localparam int SEXT_W   = 64;

  typedef logic signed [WIDTH_D-1:0] elem_t;
  typedef elem_t [N_COLS-1:0]        row_t;

  // Sign-extend the low w bits of v to SEXT_W bits (w in 1..SEXT_W).
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int unsigned w);
    logic signed [SEXT_W-1:0] t;
    t = signed'(v << (SEXT_W - w));
    return t >>> (SEXT_W - w);
  endfunction

endpackage

// File: rtl/systolic_out_packer_row_fifo.sv
// Synchronous row FIFO with occupancy count; read and write may coincide.
module row_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;

  assign rd_data = mem[rp];
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;

  // Storage write; contents need no reset since reads are qualified by empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_data;
  end

  // Pointer and occupancy update; clr flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/systolic_out_packer.sv
// Buffers systolic result rows and serialises them onto an AXI4-Stream master.
module systolic_out_packer
  import systolic_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int DEPTH    = 8,
  parameter int MAT_ROWS = 4,
  parameter int AXIS_W   = AXIS_W_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  y0,
  input  logic [WIDTH-1:0]  y1,
  input  logic [WIDTH-1:0]  y2,
  input  logic [WIDTH-1:0]  y3,
  output logic [AXIS_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              almost_full,
  output logic              overflow
);

  localparam int RW  = N_COLS * WIDTH;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int RCW = (MAT_ROWS > 1) ? $clog2(MAT_ROWS) : 1;

  logic              full, empty, push, pop, hs;
  logic [CW-1:0]     count, count_nx;
  logic [RW-1:0]     head;
  logic [1:0]        col;
  logic [RCW-1:0]    row;
  logic [WIDTH-1:0]  elem;
  logic [SEXT_W-1:0] elem_ext;

  assign m_axis_tvalid = !empty;
  assign hs   = m_axis_tvalid & m_axis_tready;
  assign pop  = hs & (col == 2'd3) & !clr;
  // A full FIFO still accepts a row when the head row leaves in the same cycle.
  assign push = in_valid & !clr & (!full | pop);

  row_fifo #(.DW(RW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (push),
    .wr_data ({y3, y2, y1, y0}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Column select of the head row, sign-extended onto the bus.
  always_comb begin
    elem = head[WIDTH-1:0];
    case (col)
      2'd1:    elem = head[2*WIDTH-1:WIDTH];
      2'd2:    elem = head[3*WIDTH-1:2*WIDTH];
      2'd3:    elem = head[4*WIDTH-1:3*WIDTH];
      default: elem = head[WIDTH-1:0];
    endcase
    elem_ext     = sext(SEXT_W'(elem), WIDTH);
    m_axis_tdata = m_axis_tvalid ? elem_ext[AXIS_W-1:0] : '0;
    m_axis_tlast = m_axis_tvalid & (row == RCW'(MAT_ROWS-1)) & (col == 2'd3);
  end

  // Next-state occupancy, used to register almost_full.
  always_comb begin
    count_nx = count;
    if (clr) count_nx = '0;
    else begin
      if (push) count_nx = count_nx + 1'b1;
      if (pop)  count_nx = count_nx - 1'b1;
    end
  end

  // Column/row beat counters advance on every handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (hs) begin
      col <= col + 1'b1;
      if (col == 2'd3)
        row <= (row == RCW'(MAT_ROWS-1)) ? '0 : row + 1'b1;
    end
  end

  // Sticky overflow and registered almost_full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow    <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (clr)                          overflow <= 1'b0;
      else if (in_valid & full & !pop)  overflow <= 1'b1;
      almost_full <= (DEPTH - int'(count_nx)) < MAT_ROWS;
    end
  end

endmodule

// File: tb/tb_systolic_out_packer.sv
// Directed and randomized bench for systolic_out_packer against an element-queue model.
module tb_systolic_out_packer;
  import systolic_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, tready;
  logic [15:0] y0, y1, y2, y3;
  logic [31:0] tdata;
  logic        tvalid, tlast, af, ovf;

  int vectors    = 0;
  int miscompares = 0;

  // Model: a flat queue of pending elements; rows resident = ceil(size/4).
  logic [15:0] mq[$];
  int          mcnt;
  logic        movf, maf;

  int A [16] = '{90, 100, 110, 120, 202, 228, 254, 280,
                 314, 356, 398, 440, 426, 484, 542, 600};

  systolic_out_packer #(.WIDTH(16), .DEPTH(DEPTH), .MAT_ROWS(4), .AXIS_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .in_valid      (in_valid),
    .y0            (y0),
    .y1            (y1),
    .y2            (y2),
    .y3            (y3),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .almost_full   (af),
    .overflow      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] x32(input logic [15:0] v);
    return 32'($signed(v));
  endfunction

  task automatic model_reset();
    mq.delete();
    mcnt = 0;
    movf = 1'b0;
    maf  = 1'b0;
  endtask

  task automatic check_outputs();
    logic        v;
    logic [31:0] ed;
    v  = (mq.size() > 0);
    ed = '0;
    if (v) ed = x32(mq[0]);
    chk("tvalid", 32'(tvalid), 32'(v));
    chk("tdata", tdata, ed);
    chk("tlast", 32'(tlast), 32'(v && mcnt == 15));
    chk("almost_full", 32'(af), 32'(maf));
    chk("overflow", 32'(ovf), 32'(movf));
    chk("count", 32'(dut.u_fifo.count), 32'((mq.size() + 3) / 4));
  endtask

  // One clock cycle: drive, check current outputs, advance model, step the edge.
  task automatic cyc(input logic iv, input logic [15:0] a, b, c, d,
                     input logic rdy, input logic cl);
    int occ;
    logic hs, popr;
    in_valid = iv; y0 = a; y1 = b; y2 = c; y3 = d; tready = rdy; clr = cl;
    #1;
    check_outputs();
    occ  = (mq.size() + 3) / 4;
    hs   = (mq.size() > 0) && rdy;
    popr = hs && (mq.size() % 4 == 1);
    if (cl) begin
      mq.delete(); mcnt = 0; movf = 1'b0;
    end else begin
      if (hs) begin
        void'(mq.pop_front());
        mcnt = (mcnt + 1) % 16;
      end
      if (iv) begin
        if (occ < DEPTH || popr) begin
          mq.push_back(a); mq.push_back(b); mq.push_back(c); mq.push_back(d);
        end else movf = 1'b1;
      end
    end
    maf = (DEPTH - (mq.size() + 3) / 4) < 4;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, '0, rdy, 1'b0);
  endtask

  task automatic push_ab(input int r, input logic rdy);
    cyc(1'b1, 16'(A[4*r]), 16'(A[4*r+1]), 16'(A[4*r+2]), 16'(A[4*r+3]), rdy, 1'b0);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; tready = 1'b0;
    y0 = '0; y1 = '0; y2 = '0; y3 = '0;
    model_reset();
    #2;
    check_outputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: back-to-back rows, sink always ready.
    for (int r = 0; r < 4; r++) push_ab(r, 1'b1);
    idle(16, 1'b1);

    // Test 2: same rows with tready toggling.
    for (int r = 0; r < 4; r++) push_ab(r, 1'(r % 2 == 0));
    for (int i = 0; i < 36; i++) idle(1, 1'(i % 2 == 0));

    // Test 3: stalled sink, nine rows, ninth dropped, then drain.
    for (int r = 0; r < 9; r++) push_ab(r % 4, 1'b0);
    idle(36, 1'b1);
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);

    // Test 4: full FIFO with coincident push and pop.
    for (int r = 0; r < 8; r++) push_ab(r % 4, 1'b0);
    idle(3, 1'b1);
    push_ab(0, 1'b1);
    chk("count_full_pushpop", 32'(dut.u_fifo.count), 32'(8));
    chk("overflow_full_pushpop", 32'(ovf), 32'(0));
    idle(40, 1'b1);
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);

    // Test 5: sign extension of boundary values.
    cyc(1'b1, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    idle(6, 1'b1);
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);

    // Test 6: reset mid-matrix, then clr over a stalled partial matrix.
    for (int r = 0; r < 4; r++) push_ab(r, 1'b1);
    idle(1, 1'b1);
    async_reset();
    push_ab(0, 1'b0);
    push_ab(1, 1'b0);
    cyc(1'b1, 16'd7, 16'd7, 16'd7, 16'd7, 1'b0, 1'b1);
    idle(1, 1'b1);
    for (int r = 0; r < 4; r++) push_ab(r, 1'b1);
    idle(16, 1'b1);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 2) == 0), 16'($urandom), 16'($urandom),
          16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 59) == 0));
    idle(40, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
